mem_port_responder: RTL
=======================

# mem_port_responder

Word-wide memory responder for the CPU's memory port, with a request/ready handshake and a programmable number of wait states. The CPU (or a bench standing in for it) is the initiator: it issues a word read or write and holds it until `ready`. The block stores bytes little-endian, flags misaligned or out-of-range accesses, and is the stalling-capable counterpart to the fixed-latency memory the datapath drives today.

## Interface
- `DEPTH_BYTES`, default 256: storage size in bytes; must be a multiple of 4.
- `WAIT_CYCLES`, default 2: extra cycles between accept and response; legal range 0..15.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  1: initiator request; `addr`/`we`/`wdata` are valid while high.
- `we`  in  1: 1 = write, 0 = read.
- `addr`  in  32: byte address of the word.
- `wdata`  in  32: write data.
- `ready`  out  1: one-cycle completion strobe.
- `rdata`  out  32: read data, registered.
- `fault`  out  1: error flag; valid in the same cycle as `ready`.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - `req`=1 latches `addr`, `we`, `wdata` and loads `cnt`=WAIT_CYCLES-1.
  - Next state is BUSY, or RESP directly when WAIT_CYCLES=0.
  - `req`=0 stays in IDLE.
- **BUSY**
  - `cnt`≠0: decrement `cnt`.
  - `cnt`=0: go to RESP.
  - `req`, `addr`, `we`, `wdata` are ignored; the latched values are used. Dropping `req` mid-access is a protocol violation, and the access still completes.
- **Edge entering RESP (access execution)**
  - A fault is raised when latched `addr[1:0]`≠0 or `addr` > DEPTH_BYTES-4.
  - Fault: `fault`←1, `rdata`←0, no storage change.
  - Read without fault: `rdata`←{mem[a+3],mem[a+2],mem[a+1],mem[a]}, where byte `a` maps to bits 7:0.
  - Write without fault: mem[a..a+3]←`wdata` (byte `a` = `wdata[7:0]`); `rdata` unchanged.
- **RESP**
  - `ready`=1 for exactly this cycle.
  - `req` is ignored; the next state is always IDLE.
- `fault` stays valid until the next RESP entry or reset.
- `rdata` holds its value until the next RESP entry or reset.
- No address wrap-around: addresses ≥ DEPTH_BYTES fault. Address arithmetic is unsigned, 32-bit.
- Storage contents are not cleared by reset and power up undefined.

## Timing
- Reset values: state IDLE, `ready`=0, `fault`=0, `rdata`=0, `cnt`=0.
- Reset mid-access aborts: the pending write is discarded, and reset wins over the RESP-entry edge.
- Latency: with `req` sampled high in IDLE in cycle 0, `ready` is high in cycle WAIT_CYCLES+1.
- Minimum request period is WAIT_CYCLES+2 cycles. An initiator holding `req` high continuously gets the next access accepted in the IDLE cycle after RESP.
- Read-after-write of the same word, in consecutive accesses, returns the new data.
- A write and a read never overlap: one outstanding access at a time.

## Structure
- Package `mem_resp_pkg`:
  - state enum {IDLE, BUSY, RESP};
  - WORD_W=32, BYTE_W=8;
  - WAIT_W=4 (counter width).
- Sub-module `mem_resp_bank`: byte array of DEPTH_BYTES with 4-byte little-endian word read and word write ports.
  - Single clock.
  - Write enable comes from the FSM on the RESP-entry edge.
  - Read is a combinational word assembly captured into `rdata` by the top.
- Top module contains the FSM, wait counter, request latches, fault decode, and output registers.

## Test plan
- After reset: `ready`=0, `fault`=0, `rdata`=0. Hold `req`=0 for 10 cycles → `ready` never asserts.
- WAIT_CYCLES=2: write 0xDEADBEEF @0x10, then read @0x10 → each `ready` arrives 3 cycles after accept. Read returns 0xDEADBEEF, `fault`=0, and byte 0x10 holds 0xEF.
- Misaligned read @0x13 and out-of-range write @0x100 (DEPTH 256) → `ready` with `fault`=1 and `rdata`=0. A subsequent read @0xFC returns prior contents unchanged.
- WAIT_CYCLES=0 with `req` held high for back-to-back reads of @0x0, @0x4 → `ready` every 2nd cycle, with correct data each time.
- Assert `reset` in the BUSY cycle of a write of 0x12345678 @0x20 → no `ready`, state IDLE, and a later read @0x20 returns the old value.
- Drop `req` during BUSY of a read @0x10 → `ready` still asserts on schedule with 0xDEADBEEF.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg
//   Shared types and constants for the memory port responder:
//   FSM state encoding, word/byte widths and the wait-counter width.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_resp_bank.sv
// mem_resp_bank
//   Byte-organised storage of DEPTH_BYTES bytes with one little-endian word
//   write port and one combinational word read port. Both ports share the
//   same word index; byte lane k of the word sits at byte address 4*word+k.
//   Contents are never reset.
// Ports:
//   clk      in   rising-edge clock
//   i_word   in   word index (byte address >> 2)
//   i_we     in   write the full word at i_word on this edge
//   i_wdata  in   write data, bits 7:0 go to the lowest byte address
//   o_rdata  out  combinational word read at i_word
module mem_resp_bank
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = $clog2(DEPTH_BYTES)
) (
  input  logic              clk,
  input  logic [ADDR_W-3:0] i_word,
  input  logic              i_we,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [BYTE_W-1:0] r_mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < 4; k++) begin
        r_mem[{i_word, 2'(k)}] <= i_wdata[k*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      o_rdata[k*BYTE_W +: BYTE_W] = r_mem[{i_word, 2'(k)}];
    end
  end

endmodule

// File: rtl/mem_port_responder.sv
// mem_port_responder
//   Word-wide memory responder with a req/ready handshake and WAIT_CYCLES
//   programmable wait states. An access is accepted in IDLE, waits in BUSY,
//   and executes on the edge that enters RESP, where ready pulses for one
//   cycle. Misaligned or out-of-range addresses raise fault and return 0
//   without touching storage.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (aborts any pending access)
//   req    in   request; addr/we/wdata valid while high
//   we     in   1 = write, 0 = read
//   addr   in   byte address of the word
//   wdata  in   write data (bits 7:0 -> lowest byte address)
//   ready  out  one-cycle completion strobe
//   rdata  out  registered read data
//   fault  out  error flag, valid with ready and held until the next access
module mem_port_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              ready,
  output logic [WORD_W-1:0] rdata,
  output logic              fault
);

  localparam int                ADDR_W   = $clog2(DEPTH_BYTES);
  localparam logic [WORD_W-1:0] MAX_ADDR = WORD_W'(DEPTH_BYTES - 4);
  localparam logic [WAIT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : WAIT_W'(WAIT_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_cnt;
  logic [WAIT_W-1:0] w_cnt_nxt;
  logic              w_enter_resp;

  logic [WORD_W-1:0] r_addr;
  logic              r_we;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_rdata;
  logic              r_fault;

  logic [WORD_W-1:0] w_acc_addr;
  logic              w_acc_we;
  logic [WORD_W-1:0] w_acc_wdata;
  logic              w_acc_fault;
  logic              w_bank_we;
  logic [WORD_W-1:0] w_bank_rdata;

  // With zero wait states RESP is entered straight from IDLE, before the
  // request latches are loaded, so the access uses the live inputs then.
  assign w_acc_addr  = (r_state == IDLE) ? addr  : r_addr;
  assign w_acc_we    = (r_state == IDLE) ? we    : r_we;
  assign w_acc_wdata = (r_state == IDLE) ? wdata : r_wdata;

  assign w_acc_fault = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr > MAX_ADDR);

  // Reset must win over the RESP-entry edge so an aborted write never lands.
  assign w_bank_we = w_enter_resp && w_acc_we && !w_acc_fault && !reset;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_cnt_nxt = CNT_LOAD;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt  = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_enter_resp) begin
        r_fault <= w_acc_fault;
        if (w_acc_fault) begin
          r_rdata <= '0;
        end else if (!w_acc_we) begin
          r_rdata <= w_bank_rdata;
        end
      end
    end
  end

  // Request latches carry data only and need no reset.
  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && req) begin
      r_addr  <= addr;
      r_we    <= we;
      r_wdata <= wdata;
    end
  end

  mem_resp_bank #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .ADDR_W     (ADDR_W)
  ) u_bank (
    .clk    (clk),
    .i_word (w_acc_addr[ADDR_W-1:2]),
    .i_we   (w_bank_we),
    .i_wdata(w_acc_wdata),
    .o_rdata(w_bank_rdata)
  );

  assign ready = (r_state == RESP);
  assign rdata = r_rdata;
  assign fault = r_fault;

endmodule
